// File: rtl/serial_addsub.sv
// ----------------------------------------------------------------------------
// serial_addsub
//
// Multi-cycle ripple add/subtract unit. It processes a WIDTH-bit operand pair
// CHUNK bits per clock. A registered carry links consecutive chunks, so the
// longest combinational path is one CHUNK-bit adder instead of a full
// WIDTH-bit ripple chain. Subtraction is computed as a + ~b + cin.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits processed per clock, 1..WIDTH
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   request; accepted only while busy=0
//   mode    in   0 = add, 1 = subtract (b inverted)
//   a, b    in   operands, sampled on accept
//   cin     in   carry-in (1 with mode=1 gives a true a-b)
//   busy    out  computation in progress
//   done    out  one-cycle pulse; result/cout/ovf valid from this cycle
//   result  out  sum/difference, held until the next completion
//   cout    out  final carry (subtract: 1 = no borrow)
//   ovf     out  two's-complement overflow
//
// Build option
//   SERIAL_ADDSUB_SAT_EN  when defined, an overflowing result is clamped to
//                         the most positive/negative value at completion.
//                         ovf and cout still describe the unclamped operation.
// ----------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;        // already inverted for subtract
   logic [WIDTH-1:0] shadow_q;   // partial result while chunks accumulate
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic             ovf_q;

   logic [CHUNK-1:0] a_ch_d;
   logic [CHUNK-1:0] b_ch_d;
   logic [CHUNK:0]   sum_d;
   logic [WIDTH-1:0] full_d;
   logic             ovf_d;
   logic [WIDTH-1:0] result_d;

   // Select the operand slice for the current chunk.
   always_comb begin
      a_ch_d = '0;
      b_ch_d = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt_q == CW'(i)) begin
            a_ch_d = a_q[i*CHUNK +: CHUNK];
            b_ch_d = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   assign sum_d = {1'b0, a_ch_d} + {1'b0, b_ch_d} + {{CHUNK{1'b0}}, carry_q};

   // Full-width view of the result as it will look once the current chunk
   // is merged; on the last chunk this is the completed sum.
   for (genvar gi = 0; gi < N; gi++) begin : g_merge
      assign full_d[gi*CHUNK +: CHUNK] =
         (cnt_q == CW'(gi)) ? sum_d[CHUNK-1:0] : shadow_q[gi*CHUNK +: CHUNK];
   end

   // Same-sign operands producing an opposite-sign result.
   assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full_d[WIDTH-1] != a_q[WIDTH-1]);

`ifdef SERIAL_ADDSUB_SAT_EN
   // Overflow direction follows the common operand sign.
   always_comb begin
      result_d = full_d;
      if (ovf_d) begin
         result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign result_d = full_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         shadow_q <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= mode ? ~b : b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               shadow_q <= full_d;
               carry_q  <= sum_d[CHUNK];
               if (cnt_q == LAST) begin
                  result_q <= result_d;
                  cout_q   <= sum_d[CHUNK];
                  ovf_q    <= ovf_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ----------------------------------------------------------------------------
// tb_serial_addsub
//
// Three instances of serial_addsub (CHUNK = 1, 4, 16 with WIDTH = 16) run the
// same directed and random sequence in parallel. Each instance has a driver
// that pushes the expected response into a queue when it issues an operation,
// and a monitor that pops and compares whenever done is seen. Expected values
// come from integer arithmetic on the operands.
// ----------------------------------------------------------------------------
module tb_serial_addsub;

   localparam int W      = 16;
   localparam int HALF   = 5;
   localparam int PERIOD = 10;
   localparam int NRAND  = 200;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         o;
      time          t;   // time of the accepting edge
   } exp_t;

   logic clk = 1'b0;
   always #HALF clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int ch, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s chunk=%0d actual=0x%0h required=0x%0h", name, ch, act, req);
      end
   endtask

   // Reference: true signed sum decides overflow, unsigned sum gives carry.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic mode, input logic cin, input time t);
      exp_t         e;
      logic [W-1:0] bp;
      logic [W:0]   s;
      longint       sv;
      longint       mx;
      longint       mn;
      bp  = mode ? ~b : b;
      s   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, cin};
      sv  = longint'($signed(a)) + longint'($signed(bp)) + longint'(cin);
      mx  = (longint'(1) <<< (W - 1)) - 1;
      mn  = -(longint'(1) <<< (W - 1));
      e.o = (sv > mx) || (sv < mn);
      e.c = s[W];
      e.r = s[W-1:0];
`ifdef SERIAL_ADDSUB_SAT_EN
      if (sv > mx) e.r = W'(mx);
      else if (sv < mn) e.r = W'(mn);
`endif
      e.t = t;
      return e;
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int CH = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
      localparam int N  = W / CH;
      localparam int RK = (N >= 2) ? 2 : 1;   // edge at which reset aborts

      logic         rst;
      logic         start;
      logic         mode;
      logic         cin;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         busy;
      logic         done;
      logic [W-1:0] result;
      logic         cout;
      logic         ovf;
      exp_t         q[$];
      bit           fin = 1'b0;

      serial_addsub #(.WIDTH(W), .CHUNK(CH)) dut (
         .clk    (clk),
         .rst    (rst),
         .start  (start),
         .mode   (mode),
         .a      (a),
         .b      (b),
         .cin    (cin),
         .busy   (busy),
         .done   (done),
         .result (result),
         .cout   (cout),
         .ovf    (ovf)
      );

      // Returns at a falling edge with busy low.
      task automatic wait_idle();
         int k;
         k = 0;
         @(negedge clk);
         while (busy === 1'b1) begin
            @(negedge clk);
            k++;
            if (k > 4 * N + 20) begin
               checks++;
               errors++;
               $display("FAIL idle_timeout chunk=%0d actual=busy required=idle", CH);
               break;
            end
         end
      endtask

      task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic im, input logic ic, input bit push);
         wait_idle();
         a     = ia;
         b     = ib;
         mode  = im;
         cin   = ic;
         start = 1'b1;
         if (push) q.push_back(model(ia, ib, im, ic, $time + HALF));
         @(posedge clk);
         #1;
         start = 1'b0;
         // Scramble inputs after accept; the running op must not notice.
         a     = W'($urandom);
         b     = W'($urandom);
         mode  = 1'($urandom);
         cin   = 1'($urandom);
      endtask

      task automatic check_zero(input string tag);
         chk({tag, "_busy"},   CH, 32'(busy),   32'd0);
         chk({tag, "_done"},   CH, 32'(done),   32'd0);
         chk({tag, "_result"}, CH, 32'(result), 32'd0);
         chk({tag, "_cout"},   CH, 32'(cout),   32'd0);
         chk({tag, "_ovf"},    CH, 32'(ovf),    32'd0);
      endtask

      // Monitor: one pop and compare per done pulse.
      always @(negedge clk) begin
         exp_t e;
         if (rst === 1'b0 && done === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done chunk=%0d actual=done required=no_done", CH);
            end else begin
               e = q.pop_front();
               $display("op chunk=%0d result=0x%04h cout=%0b ovf=%0b expected 0x%04h/%0b/%0b",
                        CH, result, cout, ovf, e.r, e.c, e.o);
               chk("result",  CH, 32'(result), 32'(e.r));
               chk("cout",    CH, 32'(cout),   32'(e.c));
               chk("ovf",     CH, 32'(ovf),    32'(e.o));
               chk("latency", CH, 32'(($time - HALF - e.t) / PERIOD), 32'(N));
            end
         end
      end

      initial begin
         rst   = 1'b1;
         start = 1'b0;
         mode  = 1'b0;
         cin   = 1'b0;
         a     = '0;
         b     = '0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check_zero("reset");
         rst = 1'b0;

         // Directed cases
         issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
         issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
         issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1);
         issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
         issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
         issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
         issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);

         // start pulsed while busy must be ignored
         issue(16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b1);
         start = 1'b1;
         a     = 16'h1111;
         b     = 16'h2222;
         repeat (RK) @(posedge clk);
         #1;
         start = 1'b0;

         // Two ops back to back (second start raised during the done cycle)
         issue(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1);
         issue(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1);

         // Abort mid-operation: outputs clear, no done for this op
         issue(16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 1'b0);
         repeat (RK - 1) begin
            @(posedge clk);
            #1;
         end
         rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check_zero("abort");
         rst = 1'b0;

         // Random operations with random idle gaps
         for (int i = 0; i < NRAND; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         end

         for (int k = 0; k < 4 * N + 20 && q.size() != 0; k++) @(negedge clk);
         chk("drain", CH, 32'(q.size()), 32'd0);
         fin = 1'b1;
      end
   end

   initial begin
      for (int k = 0; k < 60000; k++) begin
         @(posedge clk);
         if (g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) break;
      end
      if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) begin
         checks++;
         errors++;
         $display("FAIL global_timeout actual=unfinished required=finished");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
